// File: rtl/des_round_ctrl.sv
// des_round_ctrl
// Sequencer for the iterative DES round datapath. It accepts one block
// request, strobes the initial load, steps the shared round logic through
// 16 rounds while supplying the round index and key-rotation control, then
// holds the result valid until the downstream side takes it. It holds no
// data of its own.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        block request, sampled only while o_ready=1
//   i_decrypt      mode captured with an accepted i_start (1 = decrypt)
//   i_ready        downstream accepts the result while o_valid=1
//   o_ready        idle, a start this cycle is accepted
//   o_load         load IP(data) -> L/R and PC-1(key) -> C/D
//   o_round_en     commit L/R and C/D for the current round
//   o_round        current round index 0..15
//   o_shift_amt    C/D rotate amount for the current round
//   o_shift_right  rotate direction, 1 = right (decrypt)
//   o_final        last round: datapath skips the L/R swap
//   o_valid        result is stable and held
module des_round_ctrl #(
    parameter int unsigned ROUND_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_decrypt,
    input  logic       i_ready,
    output logic       o_ready,
    output logic       o_load,
    output logic       o_round_en,
    output logic [3:0] o_round,
    output logic [1:0] o_shift_amt,
    output logic       o_shift_right,
    output logic       o_final,
    output logic       o_valid
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        DONE
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(ROUND_CYCLES - 1);

    state_t     state, state_d;
    logic [3:0] round_q, round_d;
    logic [1:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;

    // Decryption walks the key schedule backwards: its first round uses the
    // unrotated PC-1 key, and the remaining amounts are the encrypt schedule
    // shifted by one round.
    function automatic logic [1:0] shift_for(input logic [3:0] r, input logic dec);
        if (r == 4'd0)
            return dec ? 2'd0 : 2'd1;
        else if (r == 4'd1 || r == 4'd8 || r == 4'd15)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    always_comb begin
        state_d = state;
        round_d = round_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_d = LOAD;
                    mode_d  = i_decrypt;
                    round_d = 4'd0;
                    cnt_d   = 2'd0;
                end
            end
            LOAD: begin
                state_d = ROUND;
            end
            ROUND: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 2'd0;
                    if (round_q == 4'd15)
                        state_d = DONE;
                    else
                        round_d = round_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (i_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and round controls are registered from the next-state values so
    // they line up with the state they describe without any input-to-output
    // combinational path.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            round_q       <= 4'd0;
            cnt_q         <= 2'd0;
            mode_q        <= 1'b0;
            o_load        <= 1'b0;
            o_round_en    <= 1'b0;
            o_shift_amt   <= 2'd0;
            o_shift_right <= 1'b0;
            o_final       <= 1'b0;
            o_valid       <= 1'b0;
        end else begin
            state         <= state_d;
            round_q       <= round_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            o_load        <= (state_d == LOAD);
            o_round_en    <= (state_d == ROUND) && (cnt_d == CNT_LAST);
            o_shift_amt   <= (state_d == ROUND) ? shift_for(round_d, mode_d) : 2'd0;
            o_shift_right <= (state_d == ROUND) && mode_d;
            o_final       <= (state_d == ROUND) && (round_d == 4'd15);
            o_valid       <= (state_d == DONE);
        end
    end

    assign o_round = round_q;
    assign o_ready = (state == IDLE);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboard bench for des_round_ctrl: two instances (ROUND_CYCLES 1 and 3).
// Issuing a block pushes the expected load / round / valid events with their
// cycle stamps; a negedge monitor pops and compares each strobe it observes.
module tb_des_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start_s, dec_s, rdy_s;

    logic       rdy0, ld0, ren0, sr0, fin0, val0;
    logic [3:0] rnd0;
    logic [1:0] amt0;
    logic       rdy1, ld1, ren1, sr1, fin1, val1;
    logic [3:0] rnd1;
    logic [1:0] amt1;

    des_round_ctrl #(.ROUND_CYCLES(1)) dut_rc1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_s[0]), .i_decrypt(dec_s[0]),
        .i_ready(rdy_s[0]), .o_ready(rdy0), .o_load(ld0), .o_round_en(ren0),
        .o_round(rnd0), .o_shift_amt(amt0), .o_shift_right(sr0),
        .o_final(fin0), .o_valid(val0)
    );

    des_round_ctrl #(.ROUND_CYCLES(3)) dut_rc3 (
        .i_clk(clk), .i_rst(rst), .i_start(start_s[1]), .i_decrypt(dec_s[1]),
        .i_ready(rdy_s[1]), .o_ready(rdy1), .o_load(ld1), .o_round_en(ren1),
        .o_round(rnd1), .o_shift_amt(amt1), .o_shift_right(sr1),
        .o_final(fin1), .o_valid(val1)
    );

    // {ready, load, round_en, round[3:0], shift_amt[1:0], shift_right, final, valid}
    logic [11:0] obs [2];
    assign obs[0] = {rdy0, ld0, ren0, rnd0, amt0, sr0, fin0, val0};
    assign obs[1] = {rdy1, ld1, ren1, rnd1, amt1, sr1, fin1, val1};

    localparam logic [11:0] IDLE_RST  = 12'h800;  // ready only, round 0
    localparam logic [11:0] DONE_HOLD = 12'h1E1;  // valid, round 15
    localparam logic [11:0] IDLE_R15  = 12'h9E0;  // ready, round held at 15

    int enc_tab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int dec_tab [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [0:0]  dut;
        logic [1:0]  kind;   // 0 load, 1 round_en, 2 valid rise
        logic [15:0] stamp;
        logic [3:0]  rnd;
        logic [1:0]  amt;
        logic        right;
        logic        fin;
    } ev_t;

    ev_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    function automatic ev_t mk_ev(input int d, input int kind, input int stamp,
                                  input int rnd, input int amt, input bit right, input bit fin);
        ev_t e;
        e.dut   = 1'(d);
        e.kind  = 2'(kind);
        e.stamp = 16'(stamp);
        e.rnd   = 4'(rnd);
        e.amt   = 2'(amt);
        e.right = right;
        e.fin   = fin;
        return e;
    endfunction

    // Monitor
    logic [1:0] prev_val = 2'b00;
    initial begin
        ev_t act;
        ev_t expv;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (obs[d][10] || obs[d][9] || (obs[d][0] && !prev_val[d])) begin
                    act.dut   = 1'(d);
                    act.kind  = obs[d][10] ? 2'd0 : (obs[d][9] ? 2'd1 : 2'd2);
                    act.stamp = cyc[15:0];
                    act.rnd   = obs[d][8:5];
                    act.amt   = obs[d][4:3];
                    act.right = obs[d][2];
                    act.fin   = obs[d][1];
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event dut%0d actual %h required none", d, act);
                    end else begin
                        expv = exp_q.pop_front();
                        chk("event", {5'b0, act}, {5'b0, expv});
                    end
                end
                prev_val[d] = obs[d][0];
            end
        end
    end

    task automatic start_block(input int d, input bit dec);
        int n;
        int e;
        int rc;
        rc = (d == 0) ? 1 : 3;
        n = 0;
        while (!obs[d][11] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!obs[d][11]) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut%0d actual 0 required 1", d);
        end
        start_s[d] = 1'b1;
        dec_s[d]   = dec;
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        dec_s[d]   = ~dec;   // must not affect the accepted block
        e = cyc;
        exp_q.push_back(mk_ev(d, 0, e, 0, 0, 1'b0, 1'b0));
        for (int r = 0; r < 16; r++)
            exp_q.push_back(mk_ev(d, 1, e + (r + 1) * rc, r,
                                  dec ? dec_tab[r] : enc_tab[r], dec, r == 15));
        exp_q.push_back(mk_ev(d, 2, e + 16 * rc + 1, 15, 0, 1'b0, 1'b0));
    endtask

    task automatic wait_valid(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!obs[d][0] && n < 200);
        if (!obs[d][0]) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout dut%0d actual 0 required 1", d);
        end
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        start_s = 2'b00;
        dec_s   = 2'b00;
        rdy_s   = 2'b11;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_rc1", {20'b0, obs[0]}, {20'b0, IDLE_RST});
            chk("idle_rc3", {20'b0, obs[1]}, {20'b0, IDLE_RST});
        end

        // Encrypt, one cycle per round, with a stray start mid-block
        start_block(0, 1'b0);
        repeat (3) @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_valid(0);
        @(negedge clk);
        chk("after_xfer_rc1", {20'b0, obs[0]}, {20'b0, IDLE_R15});

        // Decrypt, three cycles per round
        start_block(1, 1'b1);
        wait_valid(1);
        @(negedge clk);
        chk("after_xfer_rc3", {20'b0, obs[1]}, {20'b0, IDLE_R15});

        // Backpressure with ignored start pulses
        rdy_s[0] = 1'b0;
        start_block(0, 1'b0);
        wait_valid(0);
        for (int i = 0; i < 7; i++) begin
            start_s[0] = ~i[0];
            @(negedge clk);
            chk("bp_hold", {20'b0, obs[0]}, {20'b0, DONE_HOLD});
        end
        start_s[0] = 1'b0;
        rdy_s[0]   = 1'b1;
        @(negedge clk);
        chk("bp_release", {20'b0, obs[0]}, {20'b0, IDLE_R15});

        // Reset during round 7, then a fresh decrypt block
        start_block(0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (obs[0][8:5] != 4'd7 && n < 100);
        if (obs[0][8:5] != 4'd7) begin
            checks++;
            errors++;
            $display("FAIL round7_timeout actual %0d required 7", obs[0][8:5]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_reset_rc1", {20'b0, obs[0]}, {20'b0, IDLE_RST});
        chk("mid_reset_rc3", {20'b0, obs[1]}, {20'b0, IDLE_RST});
        @(negedge clk);
        chk("post_reset_idle", {20'b0, obs[0]}, {20'b0, IDLE_RST});
        start_block(0, 1'b1);
        wait_valid(0);
        @(negedge clk);
        chk("after_xfer_reset", {20'b0, obs[0]}, {20'b0, IDLE_R15});

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
